axi4_burst_master: RTL and testbench

- Command-driven AXI4 memory-mapped master; the initiator end of the AXI4 slave interface.
- Converts one write or read burst command into AW/W/B or AR/R channel traffic.
- Streams write data in and read data out; one transaction outstanding at a time.
- Sits between a test or DMA sequencer and the AXI4 slave memory.

---
 rtl/axi4_burst_master.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_axi4_burst_master.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : axi4_burst_master
// Purpose  : Command-driven AXI4 master. Turns one write or read burst command
//            into AW/W/B or AR/R traffic, streaming write data in and read
//            data out, with one transaction outstanding at a time.
// Options  : define AXI4_BURST_MASTER_TIMEOUT_EN to build the stall watchdog.
// Revision : 1.0  initial release
// ============================================================================
module axi4_burst_master #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    // command interface
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]              cmd_len,
    input  logic [2:0]              cmd_size,
    input  logic [1:0]              cmd_burst,
    // write data stream
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    // read data stream
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic [1:0]              rd_resp,
    output logic                    rd_last,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    // completion / status
    output logic                    done_valid,
    output logic [1:0]              done_resp,
    output logic                    proto_err,
    output logic                    timeout,
    // AXI4 write address channel
    output logic [ADDR_WIDTH-1:0]   AWADDR,
    output logic [7:0]              AWLEN,
    output logic [2:0]              AWSIZE,
    output logic [1:0]              AWBURST,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    // AXI4 write data channel
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic [DATA_WIDTH/8-1:0] WSTRB,
    output logic                    WLAST,
    output logic                    WVALID,
    input  logic                    WREADY,
    // AXI4 write response channel
    input  logic [1:0]              BRESP,
    input  logic                    BVALID,
    output logic                    BREADY,
    // AXI4 read address channel
    output logic [ADDR_WIDTH-1:0]   ARADDR,
    output logic [7:0]              ARLEN,
    output logic [2:0]              ARSIZE,
    output logic [1:0]              ARBURST,
    output logic                    ARVALID,
    input  logic                    ARREADY,
    // AXI4 read data channel
    input  logic [DATA_WIDTH-1:0]   RDATA,
    input  logic [1:0]              RRESP,
    input  logic                    RLAST,
    input  logic                    RVALID,
    output logic                    RREADY
);

    localparam int         c_STRB_W      = DATA_WIDTH / 8;
    localparam int         c_MAX_SIZE    = $clog2(c_STRB_W);
    localparam logic [1:0] c_BURST_INCR  = 2'b01;
    localparam logic [1:0] c_BURST_WRAP  = 2'b10;
    localparam logic [1:0] c_BURST_RSVD  = 2'b11;
    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        WR_RESP = 3'd3,
        RD_ADDR = 3'd4,
        RD_DATA = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [7:0]              r_len;
    logic [2:0]              r_size;
    logic [1:0]              r_burst;
    logic [7:0]              r_cnt;
    logic [1:0]              r_resp;
    logic                    r_proto_err;

    // Elaboration-time parameter sanity checks
    if (DATA_WIDTH < 8 || DATA_WIDTH > 128 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_data_width
        $error("axi4_burst_master: DATA_WIDTH must be a power of 2 in 8..128");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("axi4_burst_master: TIMEOUT_CYCLES must be at least 2");
    end

    // ------------------------------------------------------------------
    // Command legality: decided from the raw command so an illegal one
    // never produces bus activity.
    // ------------------------------------------------------------------
    logic [11:0] w_page_off;
    logic [15:0] w_bytes;
    logic [16:0] w_end;
    logic        w_illegal;

    if (ADDR_WIDTH >= 12) begin : g_page_off_full
        assign w_page_off = cmd_addr[11:0];
    end else begin : g_page_off_narrow
        assign w_page_off = {{(12 - ADDR_WIDTH){1'b0}}, cmd_addr};
    end

    // Total burst bytes; an INCR burst may not run past the 4KB page end
    assign w_bytes   = (16'(cmd_len) + 16'd1) << cmd_size;
    assign w_end     = {5'd0, w_page_off} + {1'b0, w_bytes};
    assign w_illegal = (cmd_burst == c_BURST_RSVD)
                     || ((cmd_burst == c_BURST_WRAP) && !((cmd_len == 8'd1) || (cmd_len == 8'd3)
                                                       || (cmd_len == 8'd7) || (cmd_len == 8'd15)))
                     || (cmd_size > 3'(c_MAX_SIZE))
                     || ((cmd_burst == c_BURST_INCR) && (w_end > 17'd4096));

    // Handshake qualifiers (outputs are only raised in their own state)
    logic w_cmd_hs, w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    assign w_cmd_hs = cmd_valid & cmd_ready;
    assign w_aw_hs  = AWVALID & AWREADY;
    assign w_w_hs   = WVALID & WREADY;
    assign w_b_hs   = BVALID & BREADY;
    assign w_ar_hs  = ARVALID & ARREADY;
    assign w_r_hs   = RVALID & RREADY;

    // Registered command fields drive both address channels directly
    assign AWADDR    = r_addr;
    assign AWLEN     = r_len;
    assign AWSIZE    = r_size;
    assign AWBURST   = r_burst;
    assign ARADDR    = r_addr;
    assign ARLEN     = r_len;
    assign ARSIZE    = r_size;
    assign ARBURST   = r_burst;
    assign WDATA     = wr_data;
    assign WSTRB     = wr_strb;
    assign WLAST     = (r_state == WR_DATA) && (r_cnt == r_len);
    assign rd_data   = RDATA;
    assign rd_resp   = RRESP;
    assign rd_last   = RLAST;
    assign done_resp = r_resp;
    assign proto_err = r_proto_err;

    // State register
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and per-state handshake outputs
    always_comb begin
        w_next     = r_state;
        cmd_ready  = 1'b0;
        AWVALID    = 1'b0;
        ARVALID    = 1'b0;
        WVALID     = 1'b0;
        wr_ready   = 1'b0;
        BREADY     = 1'b0;
        RREADY     = 1'b0;
        rd_valid   = 1'b0;
        done_valid = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (w_illegal)      w_next = DONE;
                    else if (cmd_write) w_next = WR_ADDR;
                    else                w_next = RD_ADDR;
                end
            end
            WR_ADDR: begin
                AWVALID = 1'b1;
                if (AWREADY) w_next = WR_DATA;
            end
            WR_DATA: begin
                WVALID   = wr_valid;
                wr_ready = WREADY;
                if (wr_valid && WREADY && (r_cnt == r_len)) w_next = WR_RESP;
            end
            WR_RESP: begin
                BREADY = 1'b1;
                if (BVALID) w_next = DONE;
            end
            RD_ADDR: begin
                ARVALID = 1'b1;
                if (ARREADY) w_next = RD_DATA;
            end
            RD_DATA: begin
                RREADY   = rd_ready;
                rd_valid = RVALID;
                if (RVALID && rd_ready && RLAST) w_next = DONE;
            end
            DONE: begin
                done_valid = 1'b1;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Command capture, beat counting, response aggregation, RLAST checking
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_addr      <= '0;
            r_len       <= '0;
            r_size      <= '0;
            r_burst     <= '0;
            r_cnt       <= '0;
            r_resp      <= c_RESP_OKAY;
            r_proto_err <= 1'b0;
        end else begin
            if (w_cmd_hs) begin
                r_addr  <= cmd_addr;
                r_len   <= cmd_len;
                r_size  <= cmd_size;
                r_burst <= cmd_burst;
                r_cnt   <= '0;
                r_resp  <= w_illegal ? c_RESP_SLVERR : c_RESP_OKAY;
            end
            if (w_w_hs || w_r_hs) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_b_hs) begin
                r_resp <= BRESP;
            end
            // Response codes are ordered so the numeric max is the worst one
            if (w_r_hs && (RRESP > r_resp)) begin
                r_resp <= RRESP;
            end
            // RLAST must coincide exactly with the final expected beat
            if (w_r_hs && (RLAST != (r_cnt == r_len))) begin
                r_proto_err <= 1'b1;
            end
        end
    end

`ifdef AXI4_BURST_MASTER_TIMEOUT_EN
    localparam int c_WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_WD_W-1:0] r_wd_cnt;
    logic              r_timeout;
    logic              w_active;
    logic              w_any_hs;

    assign w_active = (r_state == WR_ADDR) || (r_state == WR_DATA) || (r_state == WR_RESP)
                   || (r_state == RD_ADDR) || (r_state == RD_DATA);
    assign w_any_hs = w_aw_hs | w_w_hs | w_b_hs | w_ar_hs | w_r_hs;
    assign timeout  = r_timeout;

    // Stall watchdog: only flags, never aborts, since VALID cannot be withdrawn
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else if (!w_active || w_any_hs) begin
            r_wd_cnt <= '0;
        end else if (r_wd_cnt != c_WD_W'(TIMEOUT_CYCLES)) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
            if (r_wd_cnt == c_WD_W'(TIMEOUT_CYCLES - 1)) begin
                r_timeout <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi4_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_burst_master
// Purpose  : Self-checking bench for axi4_burst_master with a behavioural
//            slave and a command-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_axi4_burst_master;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          ACLK = 1'b0;
    logic          ARESET = 1'b1;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [7:0]    cmd_len = '0;
    logic [2:0]    cmd_size = '0;
    logic [1:0]    cmd_burst = '0;
    logic [DW-1:0] wr_data = '0;
    logic [SW-1:0] wr_strb = '0;
    logic          wr_valid = 1'b0, wr_ready;
    logic [DW-1:0] rd_data;
    logic [1:0]    rd_resp;
    logic          rd_last, rd_valid, rd_ready = 1'b0;
    logic          done_valid, proto_err, timeout;
    logic [1:0]    done_resp;
    logic [AW-1:0] AWADDR, ARADDR;
    logic [7:0]    AWLEN, ARLEN;
    logic [2:0]    AWSIZE, ARSIZE;
    logic [1:0]    AWBURST, ARBURST;
    logic          AWVALID, AWREADY = 1'b0, ARVALID, ARREADY = 1'b0;
    logic [DW-1:0] WDATA;
    logic [SW-1:0] WSTRB;
    logic          WLAST, WVALID, WREADY = 1'b0;
    logic [1:0]    BRESP = '0;
    logic          BVALID = 1'b0, BREADY;
    logic [DW-1:0] RDATA = '0;
    logic [1:0]    RRESP = '0;
    logic          RLAST = 1'b0, RVALID = 1'b0, RREADY;

    int checks = 0;
    int errors = 0;
    bit exp_proto = 1'b0;
    int dc;

    always #5 ACLK = ~ACLK;

    axi4_burst_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_resp(rd_resp), .rd_last(rd_last),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done_valid(done_valid), .done_resp(done_resp), .proto_err(proto_err), .timeout(timeout),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    // One comparison: count it, and report tag/observed/expected on mismatch
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference legality rules for a command on a 4-byte data bus
    function automatic bit legal_cmd(input logic [15:0] a, input logic [7:0] l,
                                     input logic [2:0] s, input logic [1:0] b);
        int bytes;
        bytes = (int'(l) + 1) * (1 << int'(s));
        if (b == 2'b11) return 1'b0;
        if (b == 2'b10 && !(l == 1 || l == 3 || l == 7 || l == 15)) return 1'b0;
        if (int'(s) > 2) return 1'b0;
        if (b == 2'b01 && (int'(a) % 4096) + bytes > 4096) return 1'b0;
        return 1'b1;
    endfunction

    task automatic idle_slave();
        AWREADY = 0; ARREADY = 0; WREADY = 0; BVALID = 0; RVALID = 0; RLAST = 0;
        wr_valid = 0; rd_ready = 0;
    endtask

    // Issue one command and play the slave/stream side until completion.
    // err_beat: -2 random responses, -1 all OKAY, >=0 SLVERR on that beat (or BRESP).
    // early_last: -1 normal, else RLAST is returned on that beat index.
    task automatic run_txn(input bit wr, input logic [15:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int a_delay, input int b_delay, input int early_last,
                           input int err_beat, input bit toggle, output int done_cyc);
        bit          legal, a_done, d_done, b_done, done_next, done_seen;
        int          nbeats, beat, a_cnt, b_wait;
        logic [1:0]  exp_resp, bresp;
        logic [31:0] dq[$];
        logic [3:0]  sq[$];
        logic [1:0]  rq[$];

        legal  = legal_cmd(addr, len, size, burst);
        nbeats = (early_last >= 0) ? early_last + 1 : int'(len) + 1;
        for (int i = 0; i < nbeats; i++) begin
            dq.push_back($urandom);
            sq.push_back(4'($urandom));
            if (err_beat == -2) rq.push_back(2'($urandom_range(0, 3)));
            else                rq.push_back((i == err_beat) ? 2'b10 : 2'b00);
        end
        if (err_beat == -2)     bresp = 2'($urandom_range(0, 3));
        else if (err_beat >= 0) bresp = 2'b10;
        else                    bresp = 2'b00;
        exp_resp = 2'b00;
        if (!legal) exp_resp = 2'b10;
        else if (wr) exp_resp = bresp;
        else foreach (rq[i]) if (rq[i] > exp_resp) exp_resp = rq[i];
        if (legal && !wr && early_last >= 0) exp_proto = 1'b1;

        @(negedge ACLK);
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
        cmd_size = size; cmd_burst = burst;
        #1;
        chk("cmd_ready", cmd_ready, 1'b1);
        @(negedge ACLK);
        cmd_valid = 0;

        beat = 0; a_cnt = 0; b_wait = 0; done_cyc = -1;
        a_done = 0; d_done = 0; b_done = 0; done_seen = 0; done_next = !legal;
        for (int cyc = 0; cyc < 300 && !done_seen; cyc++) begin
            AWREADY  = wr && (a_cnt >= a_delay);
            ARREADY  = !wr && (a_cnt >= a_delay);
            wr_valid = wr && (beat < nbeats) && (!toggle || ($urandom_range(0, 2) != 0));
            wr_data  = (beat < nbeats) ? dq[beat] : '0;
            wr_strb  = (beat < nbeats) ? sq[beat] : '0;
            WREADY   = !toggle || (cyc % 2 == 0);
            BVALID   = d_done && !b_done && (b_wait >= b_delay);
            BRESP    = bresp;
            RVALID   = !wr && a_done && !d_done;
            RDATA    = (beat < nbeats) ? dq[beat] : '0;
            RRESP    = (beat < nbeats) ? rq[beat] : 2'b00;
            RLAST    = (beat == nbeats - 1);
            rd_ready = !toggle || (cyc % 2 == 0);
            #1;
            if (!legal) chk("no_bus", {AWVALID, ARVALID, WVALID}, 3'b000);
            if (AWVALID) chk("aw_fields", {1'b1, AWADDR, AWLEN, AWSIZE, AWBURST}, {wr, addr, len, size, burst});
            if (ARVALID) chk("ar_fields", {1'b1, ARADDR, ARLEN, ARSIZE, ARBURST}, {!wr, addr, len, size, burst});
            if (d_done && !b_done) begin
`ifdef AXI4_BURST_MASTER_TIMEOUT_EN
                if (b_delay >= 20 && b_wait == 14) chk("timeout_early", timeout, 1'b0);
                if (b_delay >= 20 && b_wait == 17) chk("timeout_set", timeout, 1'b1);
`endif
                b_wait++;
            end
            if (AWVALID || ARVALID) a_cnt++;
            if ((AWVALID && AWREADY) || (ARVALID && ARREADY)) a_done = 1;
            chk("done_valid", done_valid, done_next);
            if (done_valid) begin
                chk("done_resp", done_resp, exp_resp);
                done_seen = 1;
                done_cyc  = cyc;
            end
            done_next = 0;
            if (wr) begin
                chk("w_gating", {WVALID, wr_ready},
                    {a_done && !d_done && wr_valid && !(AWVALID && AWREADY),
                     a_done && !d_done && WREADY && !(AWVALID && AWREADY)});
                chk("bready", BREADY, d_done && !b_done);
                if (WVALID && WREADY) begin
                    chk("w_beat", {WDATA, WSTRB, WLAST},
                        {(beat < nbeats) ? dq[beat] : 32'h0, (beat < nbeats) ? sq[beat] : 4'h0,
                         beat == int'(len)});
                    beat++;
                    if (beat > int'(len)) d_done = 1;
                end
                if (BVALID && BREADY) begin
                    b_done = 1; done_next = 1;
                end
            end else begin
                chk("r_gating", {RREADY, rd_valid},
                    {a_done && !d_done && rd_ready && !(ARVALID && ARREADY),
                     a_done && !d_done && RVALID && !(ARVALID && ARREADY)});
                if (rd_valid && rd_ready) begin
                    chk("r_beat", {rd_data, rd_resp, rd_last}, {RDATA, RRESP, RLAST});
                    chk("r_order", RDATA, (beat < nbeats) ? dq[beat] : 32'h0);
                    beat++;
                    if (RLAST) begin
                        d_done = 1; done_next = 1;
                    end
                end
            end
            @(negedge ACLK);
        end
        chk("done_seen", done_seen, 1'b1);
        idle_slave();
        #1;
        chk("post_done", {done_valid, cmd_ready}, 2'b01);
        chk("proto_err", proto_err, exp_proto);
    endtask

    initial begin
        // ---------------- reset state ----------------
        ARESET = 1;
        repeat (3) @(negedge ACLK);
        chk("reset_outs", {cmd_ready, AWVALID, ARVALID, WVALID, BREADY, RREADY, wr_ready,
                           rd_valid, done_valid, proto_err, timeout}, 11'b100_0000_0000);
        chk("reset_fields", {AWADDR, AWLEN, ARADDR, ARLEN}, 48'h0);
        ARESET = 0;

        // ---------------- directed scenarios ----------------
        // INCR write, len 3, slave always ready, OKAY response
        run_txn(1, 16'h0100, 8'd3, 3'd2, 2'b01, 0, 0, -1, -1, 0, dc);
        // INCR read, SLVERR on beat 2, rd_ready toggling
        run_txn(0, 16'h0100, 8'd3, 3'd2, 2'b01, 0, 0, -1, 2, 1, dc);
        // AWREADY held low for 5 cycles
        run_txn(1, 16'h0200, 8'd1, 3'd2, 2'b01, 5, 1, -1, -1, 0, dc);
        // ARREADY held low, FIXED read with random responses
        run_txn(0, 16'h0300, 8'd2, 3'd1, 2'b00, 4, 0, -1, -2, 0, dc);
        // Illegal commands: WRAP len 2, RSVD burst, 4KB crossing, oversize
        run_txn(1, 16'h0100, 8'd2, 3'd2, 2'b10, 0, 0, -1, -1, 0, dc);
        run_txn(0, 16'h0100, 8'd0, 3'd2, 2'b11, 0, 0, -1, -1, 0, dc);
        run_txn(1, 16'h0FF8, 8'd3, 3'd2, 2'b01, 0, 0, -1, -1, 0, dc);
        run_txn(0, 16'h0FF8, 8'd3, 3'd2, 2'b01, 0, 0, -1, -1, 0, dc);
        run_txn(0, 16'h0000, 8'd0, 3'd3, 2'b01, 0, 0, -1, -1, 0, dc);
        // Legal boundary: INCR ending exactly at page end, WRAP len 7
        run_txn(1, 16'h0FF0, 8'd3, 3'd2, 2'b01, 0, 0, -1, -1, 0, dc);
        run_txn(0, 16'h0040, 8'd7, 3'd2, 2'b10, 0, 0, -1, -2, 1, dc);
        // Minimum latency: accept N, AW N+1, W N+2, B N+3, done N+4
        run_txn(1, 16'h0400, 8'd0, 3'd2, 2'b01, 0, 0, -1, -1, 0, dc);
        chk("min_latency", dc, 3);
        // Early RLAST sets sticky proto_err; a clean read keeps it set
        run_txn(0, 16'h0500, 8'd3, 3'd2, 2'b01, 0, 0, 1, -1, 0, dc);
        run_txn(0, 16'h0600, 8'd1, 3'd2, 2'b01, 0, 0, -1, -1, 0, dc);

        // ---------------- reset in the middle of RD_DATA ----------------
        @(negedge ACLK);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 16'h0700; cmd_len = 8'd3;
        cmd_size = 3'd2; cmd_burst = 2'b01;
        @(negedge ACLK);
        cmd_valid = 0; ARREADY = 1;
        @(negedge ACLK);
        ARREADY = 0; RVALID = 1; RLAST = 0; RDATA = $urandom; RRESP = 2'b00; rd_ready = 1;
        #1;
        chk("rd_mid", {RREADY, rd_valid}, 2'b11);
        @(negedge ACLK);
        ARESET = 1;
        @(negedge ACLK);
        #1;
        chk("reset_mid", {RREADY, rd_valid, cmd_ready, proto_err}, 4'b0010);
        exp_proto = 0;
        ARESET = 0;
        idle_slave();

        // ---------------- long B stall (watchdog when built in) ----------------
        run_txn(1, 16'h0800, 8'd0, 3'd2, 2'b01, 0, 20, -1, -1, 0, dc);
`ifndef AXI4_BURST_MASTER_TIMEOUT_EN
        chk("timeout_tied", timeout, 1'b0);
`endif

        // ---------------- randomized commands ----------------
        for (int n = 0; n < 24; n++) begin
            run_txn(1'($urandom), 16'($urandom), 8'($urandom_range(0, 15)),
                    3'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    $urandom_range(0, 3), $urandom_range(0, 3), -1, -2,
                    1'($urandom), dc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
